// File: rtl/toy_trap_arb_if.sv
// Handshake and payload bundle between exception sources, the trap
// arbiter and the CSR/debug controller.
interface toy_trap_arb_if #(
    parameter int NUM_SRC    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
);
    logic [NUM_SRC-1:0]            src_vld;
    logic [NUM_SRC*32-1:0]         src_cause;
    logic [NUM_SRC*ADDR_WIDTH-1:0] src_pc;
    logic [NUM_SRC*INST_WIDTH-1:0] src_inst;
    logic [NUM_SRC-1:0]            src_ack;
    logic                          flush;
    logic                          debug_mode_en;
    logic                          debug_ebreakm;
    logic                          debug_step_en;
    logic                          debug_step_release;
    logic [ADDR_WIDTH-1:0]         csr_mtvec;
    logic                          trap_vld;
    logic                          trap_rdy;
    logic [ADDR_WIDTH-1:0]         trap_pc;
    logic [31:0]                   trap_cause;
    logic [INST_WIDTH-1:0]         trap_extra_info;
    logic                          trap_indebug;
    logic                          indebug_break_en;
    logic                          indebug_exception;
    logic                          debug_vld;
    logic                          debug_rdy;
    logic [2:0]                    debug_cause;
    logic [ADDR_WIDTH-1:0]         debug_pc;
    logic                          busy;

    // Exec units and CSR/debug side
    modport master (
        output src_vld, src_cause, src_pc, src_inst, flush,
               debug_mode_en, debug_ebreakm, debug_step_en, debug_step_release,
               csr_mtvec, trap_rdy, debug_rdy,
        input  src_ack, trap_vld, trap_pc, trap_cause, trap_extra_info,
               trap_indebug, indebug_break_en, indebug_exception,
               debug_vld, debug_cause, debug_pc, busy
    );

    // Arbiter side
    modport slave (
        input  src_vld, src_cause, src_pc, src_inst, flush,
               debug_mode_en, debug_ebreakm, debug_step_en, debug_step_release,
               csr_mtvec, trap_rdy, debug_rdy,
        output src_ack, trap_vld, trap_pc, trap_cause, trap_extra_info,
               trap_indebug, indebug_break_en, indebug_exception,
               debug_vld, debug_cause, debug_pc, busy
    );
endinterface

// File: rtl/toy_trap_arb.sv
// Fixed-priority exception arbiter (source 0 highest). The winner is
// classified as a normal trap or a debug entry and parked in a one-entry
// holding stage until the matching valid/ready handshake or a flush.
//
// state     | meaning
// IDLE      | holding stage empty, granting the lowest requesting source
// TRAP_PEND | normal trap presented on trap_vld, waiting for trap_rdy
// DBG_PEND  | debug entry presented on debug_vld, waiting for debug_rdy
module toy_trap_arb #(
    parameter int NUM_SRC    = 2,
    parameter int ADDR_WIDTH = 32,
    parameter int INST_WIDTH = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    toy_trap_arb_if.slave bus
);
    localparam logic [31:0] MCAUSE_BREAK   = 32'd3;
    localparam logic [31:0] DEBUG_HALT_REQ = 32'h0000_0100;
    localparam logic [2:0]  DM_EBREAK      = 3'd1;
    localparam logic [2:0]  DM_HALT_REQ    = 3'd3;
    localparam logic [2:0]  DM_STEP        = 3'd4;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        TRAP_PEND = 2'd1,
        DBG_PEND  = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_step;
    logic                  r_trap_vld;
    logic                  r_debug_vld;
    logic [ADDR_WIDTH-1:0] r_pc;
    logic [31:0]           r_cause;
    logic [INST_WIDTH-1:0] r_inst;
    logic                  r_ibrk;
    logic                  r_iexc;
    logic                  r_indebug;
    logic [2:0]            r_dcause;
    logic [ADDR_WIDTH-1:0] r_dpc;

    logic                  w_any;
    logic [NUM_SRC-1:0]    w_grant;
    logic [31:0]           w_cause;
    logic [ADDR_WIDTH-1:0] w_pc;
    logic [INST_WIDTH-1:0] w_inst;
    logic                  w_halt;
    logic                  w_brk;
    logic                  w_dm_ebreak;
    logic                  w_dm_step;
    logic                  w_debug;
    logic [2:0]            w_dcause;
    logic                  w_hs;

    // Lowest-index requester wins; scanning downward lets it overwrite the rest
    always_comb begin
        w_any   = 1'b0;
        w_grant = '0;
        w_cause = '0;
        w_pc    = '0;
        w_inst  = '0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (bus.src_vld[i]) begin
                w_any      = 1'b1;
                w_grant    = '0;
                w_grant[i] = 1'b1;
                w_cause    = bus.src_cause[32*i +: 32];
                w_pc       = bus.src_pc[ADDR_WIDTH*i +: ADDR_WIDTH];
                w_inst     = bus.src_inst[INST_WIDTH*i +: INST_WIDTH];
            end
        end
    end

    // Classify the winner against the live debug controls
    always_comb begin
        w_halt      = (w_cause == DEBUG_HALT_REQ);
        w_brk       = (w_cause == MCAUSE_BREAK);
        w_dm_ebreak = w_brk & ~bus.debug_mode_en & bus.debug_ebreakm & ~bus.debug_step_en;
        w_dm_step   = w_brk & ~bus.debug_mode_en & bus.debug_ebreakm & bus.debug_step_en;
        w_debug     = w_halt | w_dm_ebreak | w_dm_step;
        if (w_dm_ebreak)    w_dcause = DM_EBREAK;
        else if (w_halt)    w_dcause = DM_HALT_REQ;
        else if (w_dm_step) w_dcause = DM_STEP;
        else                w_dcause = 3'd0;
    end

    assign w_hs = (r_trap_vld & bus.trap_rdy) | (r_debug_vld & bus.debug_rdy);

    // Capture, hold and release of the single pending entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_trap_vld  <= 1'b0;
            r_debug_vld <= 1'b0;
            r_pc        <= '0;
            r_cause     <= '0;
            r_inst      <= '0;
            r_ibrk      <= 1'b0;
            r_iexc      <= 1'b0;
            r_indebug   <= 1'b0;
            r_dcause    <= '0;
            r_dpc       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_state     <= w_debug ? DBG_PEND : TRAP_PEND;
                        r_trap_vld  <= ~w_debug;
                        r_debug_vld <= w_debug;
                        r_pc        <= w_pc;
                        r_cause     <= w_cause;
                        r_inst      <= w_inst;
                        r_ibrk      <= w_brk & bus.debug_mode_en;
                        r_iexc      <= ~w_brk & ~w_halt & bus.debug_mode_en;
                        r_indebug   <= bus.debug_mode_en & ~w_halt;
                        r_dcause    <= w_dcause;
                        r_dpc       <= w_debug ? (r_step ? bus.csr_mtvec : w_pc) : '0;
                    end
                end
                TRAP_PEND, DBG_PEND: begin
                    // a coinciding handshake and flush both end in IDLE
                    if (w_hs || bus.flush) begin
                        r_state     <= IDLE;
                        r_trap_vld  <= 1'b0;
                        r_debug_vld <= 1'b0;
                        r_pc        <= '0;
                        r_cause     <= '0;
                        r_inst      <= '0;
                        r_ibrk      <= 1'b0;
                        r_iexc      <= 1'b0;
                        r_indebug   <= 1'b0;
                        r_dcause    <= '0;
                        r_dpc       <= '0;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Step flag remembers that a trap was taken during single-step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                                         r_step <= 1'b0;
        else if (bus.debug_step_release)                    r_step <= 1'b0;
        else if (r_trap_vld && bus.trap_rdy && bus.debug_step_en) r_step <= 1'b1;
    end

    assign bus.src_ack           = (r_state == IDLE && rst_n) ? w_grant : '0;
    assign bus.trap_vld          = r_trap_vld;
    assign bus.debug_vld         = r_debug_vld;
    assign bus.trap_pc           = r_pc;
    assign bus.trap_cause        = r_cause;
    assign bus.trap_extra_info   = r_inst;
    assign bus.indebug_break_en  = r_ibrk;
    assign bus.indebug_exception = r_iexc;
    assign bus.trap_indebug      = r_indebug;
    assign bus.debug_cause       = r_dcause;
    assign bus.debug_pc          = r_dpc;
    assign bus.busy              = r_trap_vld | r_debug_vld;
endmodule

// File: tb/tb_toy_trap_arb.sv
// Bench for toy_trap_arb: a transaction-level model predicts grants and
// pending entries; a negedge monitor compares the DUT against a scoreboard.
module tb_toy_trap_arb;
    localparam int NS = 2;
    localparam int AW = 32;
    localparam int IW = 32;
    localparam logic [31:0] BREAK_C = 32'd3;
    localparam logic [31:0] HALT_C  = 32'h0000_0100;

    typedef struct {
        bit          dbg;
        logic [31:0] pc;
        logic [31:0] cause;
        logic [31:0] inst;
        bit          ibrk;
        bit          iexc;
        logic [2:0]  dcause;
        logic [31:0] dpc;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    toy_trap_arb_if #(.NUM_SRC(NS), .ADDR_WIDTH(AW), .INST_WIDTH(IW)) bus ();
    toy_trap_arb #(.NUM_SRC(NS), .ADDR_WIDTH(AW), .INST_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    bit          req_v [NS];
    logic [31:0] req_cause [NS];
    logic [31:0] req_pc [NS];
    logic [31:0] req_inst [NS];
    bit c_trap_rdy, c_debug_rdy, c_flush, c_mode, c_ebreakm, c_stepen, c_release;
    logic [31:0] c_mtvec = 32'h8000_0040;

    int          m_kind = 0;     // 0 empty, 1 trap pending, 2 debug pending
    bit          m_step = 0;
    exp_t        sb [$];
    int          exp_kind = 0;
    logic [NS-1:0] exp_ack = '0;
    bit          mon_en = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clear_ctl();
        c_trap_rdy = 0; c_debug_rdy = 0; c_flush = 0; c_mode = 0;
        c_ebreakm = 0; c_stepen = 0; c_release = 0;
    endtask

    // One clock of stimulus plus the reference model's view of that clock
    task automatic run_cycle();
        logic [NS-1:0]    v;
        logic [NS*32-1:0] vc, vp, vi;
        exp_t e;
        int   w;
        bit   hs, set_flag, halt, brk, dm_eb, dm_st;
        @(posedge clk); #1;
        for (int i = 0; i < NS; i++) begin
            v[i] = req_v[i];
            vc[32*i +: 32] = req_cause[i];
            vp[32*i +: 32] = req_pc[i];
            vi[32*i +: 32] = req_inst[i];
        end
        bus.src_vld = v; bus.src_cause = vc; bus.src_pc = vp; bus.src_inst = vi;
        bus.trap_rdy = c_trap_rdy; bus.debug_rdy = c_debug_rdy; bus.flush = c_flush;
        bus.debug_mode_en = c_mode; bus.debug_ebreakm = c_ebreakm;
        bus.debug_step_en = c_stepen; bus.debug_step_release = c_release;
        bus.csr_mtvec = c_mtvec;

        exp_kind = m_kind;
        exp_ack  = '0;
        set_flag = 0;
        if (m_kind == 0) begin
            w = -1;
            for (int i = NS - 1; i >= 0; i--) if (req_v[i]) w = i;
            if (w >= 0) begin
                exp_ack[w] = 1'b1;
                halt  = (req_cause[w] == HALT_C);
                brk   = (req_cause[w] == BREAK_C);
                dm_eb = brk && !c_mode && c_ebreakm && !c_stepen;
                dm_st = brk && !c_mode && c_ebreakm && c_stepen;
                e.dbg    = halt || dm_eb || dm_st;
                e.pc     = req_pc[w];
                e.cause  = req_cause[w];
                e.inst   = req_inst[w];
                e.ibrk   = brk && c_mode;
                e.iexc   = !brk && !halt && c_mode;
                e.dcause = dm_eb ? 3'd1 : halt ? 3'd3 : dm_st ? 3'd4 : 3'd0;
                e.dpc    = m_step ? c_mtvec : req_pc[w];
                sb.push_back(e);
                m_kind   = e.dbg ? 2 : 1;
                req_v[w] = 0;
            end
        end else begin
            hs = (m_kind == 1 && c_trap_rdy) || (m_kind == 2 && c_debug_rdy);
            if (hs && m_kind == 1 && c_stepen) set_flag = 1;
            if (hs || c_flush) m_kind = 0;
        end
        if (c_release) m_step = 0;
        else if (set_flag) m_step = 1;
    endtask

    task automatic new_req(int i, logic [31:0] cause);
        req_v[i] = 1; req_cause[i] = cause;
        req_pc[i] = $urandom & 32'hFFFF_FFFC; req_inst[i] = $urandom;
    endtask

    // Monitor: compare what the DUT presents against the scoreboard head
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                chk("src_ack", 64'(bus.src_ack), 64'(exp_ack));
                chk("trap_vld", 64'(bus.trap_vld), 64'(exp_kind == 1));
                chk("debug_vld", 64'(bus.debug_vld), 64'(exp_kind == 2));
                chk("busy", 64'(bus.busy), 64'(exp_kind != 0));
                if (exp_kind == 0) begin
                    chk("idle_trap_pc", 64'(bus.trap_pc), 64'd0);
                    chk("idle_trap_cause", 64'(bus.trap_cause), 64'd0);
                    chk("idle_extra", 64'(bus.trap_extra_info), 64'd0);
                end else if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL scoreboard_empty actual=pending expected=entry at %0t", $time);
                end else begin
                    e = sb[0];
                    if (exp_kind == 1) begin
                        chk("trap_pc", 64'(bus.trap_pc), 64'(e.pc));
                        chk("trap_cause", 64'(bus.trap_cause), 64'(e.cause));
                        chk("trap_extra", 64'(bus.trap_extra_info), 64'(e.inst));
                        chk("indebug_break", 64'(bus.indebug_break_en), 64'(e.ibrk));
                        chk("indebug_exc", 64'(bus.indebug_exception), 64'(e.iexc));
                        chk("trap_indebug", 64'(bus.trap_indebug), 64'(e.ibrk | e.iexc));
                    end else begin
                        chk("debug_cause", 64'(bus.debug_cause), 64'(e.dcause));
                        chk("debug_pc", 64'(bus.debug_pc), 64'(e.dpc));
                    end
                    if ((exp_kind == 1 && bus.trap_rdy) || (exp_kind == 2 && bus.debug_rdy) || bus.flush)
                        void'(sb.pop_front());
                end
            end
        end
    end

    initial begin
        clear_ctl();
        for (int i = 0; i < NS; i++) begin
            req_v[i] = 0; req_cause[i] = '0; req_pc[i] = '0; req_inst[i] = '0;
        end
        bus.src_vld = '0; bus.src_cause = '0; bus.src_pc = '0; bus.src_inst = '0;
        bus.trap_rdy = 0; bus.debug_rdy = 0; bus.flush = 0; bus.debug_mode_en = 0;
        bus.debug_ebreakm = 0; bus.debug_step_en = 0; bus.debug_step_release = 0;
        bus.csr_mtvec = c_mtvec;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_trap_vld", 64'(bus.trap_vld), 64'd0);
        chk("rst_debug_vld", 64'(bus.debug_vld), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        chk("rst_debug_cause", 64'(bus.debug_cause), 64'd0);
        chk("rst_debug_pc", 64'(bus.debug_pc), 64'd0);
        chk("rst_trap_indebug", 64'(bus.trap_indebug), 64'd0);
        @(negedge clk); rst_n = 1;
        mon_en = 1;
        run_cycle();

        // both sources: priority, then source 1 two cycles later
        new_req(0, 32'd2); new_req(1, 32'd5); c_trap_rdy = 1;
        repeat (5) run_cycle();

        // ebreak outside debug mode with ebreakm
        clear_ctl(); new_req(0, BREAK_C); c_ebreakm = 1; c_debug_rdy = 1;
        repeat (3) run_cycle();

        // step: trap accepted sets flag, ebreak then redirects to mtvec
        clear_ctl(); c_stepen = 1; c_trap_rdy = 1; new_req(0, 32'd7);
        repeat (3) run_cycle();
        c_ebreakm = 1; c_debug_rdy = 1; new_req(0, BREAK_C);
        repeat (3) run_cycle();
        c_release = 1; run_cycle(); c_release = 0;
        new_req(0, BREAK_C);
        repeat (3) run_cycle();

        // ebreak while already in debug mode stays a normal trap
        clear_ctl(); c_mode = 1; c_ebreakm = 1; c_trap_rdy = 1; new_req(0, BREAK_C);
        repeat (3) run_cycle();

        // stall with churning source inputs, then flush
        clear_ctl(); new_req(0, 32'd9); run_cycle();
        for (int k = 0; k < 5; k++) begin
            new_req(1, $urandom_range(0, 15));
            run_cycle();
        end
        c_flush = 1; run_cycle(); c_flush = 0;
        c_trap_rdy = 1; repeat (3) run_cycle();

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NS; i++) begin
                if (!req_v[i] && $urandom_range(0, 2) == 0) begin
                    case ($urandom_range(0, 7))
                        0: new_req(i, BREAK_C);
                        1: new_req(i, HALT_C);
                        default: new_req(i, 32'($urandom_range(0, 15)));
                    endcase
                end
            end
            c_trap_rdy  = ($urandom_range(0, 9) < 6);
            c_debug_rdy = ($urandom_range(0, 9) < 6);
            c_flush     = ($urandom_range(0, 9) == 0);
            c_mode      = ($urandom_range(0, 3) == 0);
            c_ebreakm   = ($urandom_range(0, 9) < 7);
            c_stepen    = ($urandom_range(0, 9) < 4);
            c_release   = ($urandom_range(0, 19) < 3);
            if ($urandom_range(0, 15) == 0) c_mtvec = $urandom & 32'hFFFF_FFFC;
            run_cycle();
        end

        // drain, then async reset in the middle of a pending debug entry
        clear_ctl(); c_trap_rdy = 1; c_debug_rdy = 1;
        for (int i = 0; i < NS; i++) req_v[i] = 0;
        repeat (4) run_cycle();
        clear_ctl(); new_req(0, HALT_C);
        run_cycle(); run_cycle();
        @(posedge clk); #3;
        mon_en = 0;
        bus.src_vld = '0;
        rst_n = 0;
        #1;
        chk("arst_debug_vld", 64'(bus.debug_vld), 64'd0);
        chk("arst_trap_vld", 64'(bus.trap_vld), 64'd0);
        chk("arst_busy", 64'(bus.busy), 64'd0);
        chk("arst_debug_cause", 64'(bus.debug_cause), 64'd0);
        chk("arst_debug_pc", 64'(bus.debug_pc), 64'd0);
        chk("arst_trap_cause", 64'(bus.trap_cause), 64'd0);
        chk("arst_src_ack", 64'(bus.src_ack), 64'd0);
        m_kind = 0; m_step = 0; sb.delete(); exp_kind = 0; exp_ack = '0;
        #20 rst_n = 1;
        mon_en = 1;
        repeat (3) run_cycle();
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
